// File: rtl/row_feeder_3line_pkg.sv
// Shared image-pipeline definitions: the row feeder's state encoding and the
// default frame geometry.
package row_feeder_3line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    localparam int DEF_PIXEL_SIZE = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

endpackage

// File: rtl/row_feeder_3line_line_ram.sv
// One image row of pixels. The read is combinational so a same-cycle write to
// the same address still returns the previous contents.
module line_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/row_feeder_3line.sv
// Turns a raster pixel stream into aligned 3-row columns (rows r-2, r-1, r)
// for a 3x3 window, using two line memories that shift one row per pass.
module row_feeder_3line
    import row_feeder_3line_pkg::*;
#(
    parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sof,
    input  logic                  in_valid,
    input  logic [PIXEL_SIZE-1:0] in_pixel,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [PIXEL_SIZE-1:0] row0_out,
    output logic [PIXEL_SIZE-1:0] row1_out,
    output logic [PIXEL_SIZE-1:0] row2_out,
    output logic                  out_row_start,
    output logic                  frame_done,
    output logic                  frame_abort
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    feeder_state_e         state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [PIXEL_SIZE-1:0] row0_q, row0_d;
    logic [PIXEL_SIZE-1:0] row1_q, row1_d;
    logic [PIXEL_SIZE-1:0] row2_q, row2_d;
    logic                  out_valid_q, out_valid_d;
    logic                  row_start_q, row_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_abort_q, frame_abort_d;

    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic [PIXEL_SIZE-1:0] lb0_rdata;
    logic [PIXEL_SIZE-1:0] lb1_rdata;

    // sof wins over any same-cycle pixel, so the restart never half-accepts.
    assign in_ready = ((state_q == ST_FILL) || (state_q == ST_STREAM)) && !sof;
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

    line_ram #(.WIDTH(PIXEL_SIZE), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb1_rdata),
        .rdata (lb0_rdata)
    );

    line_ram #(.WIDTH(PIXEL_SIZE), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (in_pixel),
        .rdata (lb1_rdata)
    );

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        row0_d        = row0_q;
        row1_d        = row1_q;
        row2_d        = row2_q;
        out_valid_d   = 1'b0;
        row_start_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;

        if (sof) begin
            frame_abort_d = (state_q == ST_FILL) || (state_q == ST_STREAM);
            col_d         = '0;
            row_d         = '0;
            state_d       = ST_FILL;
        end else if (accept) begin
            if (row_q >= RW'(2)) begin
                row0_d      = lb0_rdata;
                row1_d      = lb1_rdata;
                row2_d      = in_pixel;
                out_valid_d = 1'b1;
                row_start_d = (col_q == '0);
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if ((state_q == ST_FILL) && (row_q == RW'(1)) && last_col) begin
                state_d = ST_STREAM;
            end
            if ((state_q == ST_STREAM) && last_row && last_col) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            row0_q        <= '0;
            row1_q        <= '0;
            row2_q        <= '0;
            out_valid_q   <= 1'b0;
            row_start_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            row0_q        <= row0_d;
            row1_q        <= row1_d;
            row2_q        <= row2_d;
            out_valid_q   <= out_valid_d;
            row_start_q   <= row_start_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_row_start = row_start_q;
    assign frame_done    = frame_done_q;
    assign frame_abort   = frame_abort_q;
    assign row0_out      = row0_q;
    assign row1_out      = row1_q;
    assign row2_out      = row2_q;

endmodule

// File: tb/tb_row_feeder_3line.sv
// Bench for row_feeder_3line on a 4x4 frame: a directed vector table, corner
// sequences and randomized frames checked against a pixel-count image model.
module tb_row_feeder_3line;

    localparam int P = 8;
    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sof;
    logic         in_valid;
    logic [P-1:0] in_pixel;
    logic         in_ready;
    logic         out_valid;
    logic [P-1:0] row0_out, row1_out, row2_out;
    logic         out_row_start;
    logic         frame_done;
    logic         frame_abort;

    row_feeder_3line #(.PIXEL_SIZE(P), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sof           (sof),
        .in_valid      (in_valid),
        .in_pixel      (in_pixel),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .row0_out      (row0_out),
        .row1_out      (row1_out),
        .row2_out      (row2_out),
        .out_row_start (out_row_start),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: a frame is "open" after sof until W*H pixels have been
    // taken; pixel k lands at row k/W, column k%W of the stored image.
    bit          m_in_frame;
    int          m_n;
    logic [P-1:0] m_img [H][W];
    logic [3:0]  e_ctl;   // {out_valid, out_row_start, frame_done, frame_abort}
    logic [23:0] e_rows;
    logic        ready_seen;
    int          ov_count;

    typedef struct {
        logic         sof;
        logic         valid;
        logic [P-1:0] pix;
        logic         exp_ready;
        logic [3:0]   exp_ctl;
        logic [23:0]  exp_rows;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_n        = 0;
        e_ctl      = '0;
        e_rows     = '0;
    endtask

    // One clock cycle: drive at the falling edge, check ready, then check the
    // registered outputs at the next falling edge.
    task automatic step(input logic s, input logic v, input logic [P-1:0] p);
        logic ready_e;
        int r, c;
        sof      = s;
        in_valid = v;
        in_pixel = p;
        #1;
        ready_e    = m_in_frame && !s;
        ready_seen = in_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, ready_e});
        e_ctl = '0;
        if (s) begin
            e_ctl[0]   = m_in_frame;
            m_in_frame = 1'b1;
            m_n        = 0;
        end else if (v && ready_e) begin
            r = m_n / W;
            c = m_n % W;
            if (r >= 2) begin
                e_rows   = {m_img[r-2][c], m_img[r-1][c], p};
                e_ctl[3] = 1'b1;
                e_ctl[2] = (c == 0);
            end
            m_img[r][c] = p;
            m_n++;
            if (m_n == W * H) begin
                m_in_frame = 1'b0;
                e_ctl[1]   = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("ctl", {28'd0, out_valid, out_row_start, frame_done, frame_abort}, {28'd0, e_ctl});
        chk("rows", {8'd0, row0_out, row1_out, row2_out}, {8'd0, e_rows});
        if (out_valid) ov_count++;
    endtask

    function automatic logic [P-1:0] pix_of(input int k);
        pix_of = P'(16 * (k / W) + (k % W));
    endfunction

    task automatic send_frame_pixels(input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            step(1'b0, 1'b1, pix_of(k));
        end
    endtask

    initial begin
        int k, idx;
        rst_n    = 1'b0;
        sof      = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        model_reset();
        ov_count = 0;

        // Vector table: idle ignore, sof with pixel, full frame, DONE hold, sof in DONE.
        vecs[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 4'b0000, 24'h000000};
        vecs[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 4'b0000, 24'h000000};
        for (int i = 0; i < 16; i++) begin
            int r, c;
            r = i / W;
            c = i % W;
            vecs[2+i].sof       = 1'b0;
            vecs[2+i].valid     = 1'b1;
            vecs[2+i].pix       = P'(16 * r + c);
            vecs[2+i].exp_ready = 1'b1;
            if (r >= 2) begin
                vecs[2+i].exp_ctl  = {1'b1, c == 0, i == 15, 1'b0};
                vecs[2+i].exp_rows = {8'(16 * (r - 2) + c), 8'(16 * (r - 1) + c), 8'(16 * r + c)};
            end else begin
                vecs[2+i].exp_ctl  = 4'b0000;
                vecs[2+i].exp_rows = 24'h000000;
            end
        end
        vecs[18] = '{1'b0, 1'b1, 8'h99, 1'b0, 4'b0000, 24'h132333};
        vecs[19] = '{1'b1, 1'b1, 8'h77, 1'b0, 4'b0000, 24'h132333};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", {25'd0, in_ready, out_valid, out_row_start, frame_done, frame_abort,
                           (row0_out | row1_out | row2_out) != 0}, 32'd0);
        rst_n = 1'b1;

        ov_count = 0;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].sof, vecs[i].valid, vecs[i].pix);
            chk("tbl_ready", {31'd0, ready_seen}, {31'd0, vecs[i].exp_ready});
            chk("tbl_ctl", {28'd0, out_valid, out_row_start, frame_done, frame_abort},
                {28'd0, vecs[i].exp_ctl});
            chk("tbl_rows", {8'd0, row0_out, row1_out, row2_out}, {8'd0, vecs[i].exp_rows});
        end
        chk("frame_pulses", ov_count, 32'd8);

        // in_valid toggling every cycle: same columns, output only after accepts.
        step(1'b0, 1'b0, 8'h00);
        ov_count = 0;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, (i % 2) == 0, pix_of(k));
            if ((i % 2) == 0) k++;
        end
        chk("toggle_pulses", ov_count, 32'd8);

        // Abort after pixel (2,1), then a fresh frame.
        step(1'b1, 1'b0, 8'h00);
        send_frame_pixels(0, 10);
        step(1'b1, 1'b0, 8'h00);
        chk("abort_seen", {31'd0, frame_abort}, 32'd1);
        ov_count = 0;
        send_frame_pixels(0, 8);
        chk("fill_quiet", ov_count, 32'd0);
        send_frame_pixels(8, 1);
        chk("first_col", {8'd0, row0_out, row1_out, row2_out}, 32'h00001020);
        send_frame_pixels(9, 7);

        // DONE with in_valid high, then sof with in_valid in the same cycle.
        step(1'b0, 1'b1, 8'hEE);
        step(1'b1, 1'b1, 8'hEE);

        // Asynchronous reset mid-STREAM.
        send_frame_pixels(0, 11);
        sof      = 1'b0;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr", {25'd0, in_ready, out_valid, out_row_start, frame_done, frame_abort,
                          (row0_out | row1_out | row2_out) != 0}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h00);
        ov_count = 0;
        send_frame_pixels(0, 16);
        chk("post_reset_pulses", ov_count, 32'd8);

        // Randomized frames with random gaps, pixels and occasional restarts.
        for (int f = 0; f < 4; f++) begin
            step(1'b1, 1'b0, 8'h00);
            idx = 0;
            while (m_in_frame && idx < 300) begin
                step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), P'($urandom));
                idx++;
            end
            if (m_in_frame) chk("rand_budget", 32'd0, 32'd1);
            step(1'b0, 1'b1, P'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
